// File: rtl/core_mem_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package core_mem_pkg;

  localparam int unsigned CORE_XLEN = 32;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } mem_size_e;

  localparam logic [CORE_XLEN-1:0] EXC_LOAD_MISALIGN  = 32'd4;
  localparam logic [CORE_XLEN-1:0] EXC_STORE_MISALIGN = 32'd6;

  // Reserved funct3 codes (011, 11x) fall through to word access.
  function automatic mem_size_e op_size(input logic [2:0] op);
    case (op)
      MEM_B, MEM_BU: return SZ_B;
      MEM_H, MEM_HU: return SZ_H;
      default:       return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/core_mem_if.sv
// EX/MEM handshake and data-bus interfaces for the MEM stage.
interface core_mem_em_if;
  import core_mem_pkg::*;

  logic                 em_valid;
  logic                 em_ready;
  logic [CORE_XLEN-1:0] em_reg_data_mem_addr;
  logic [CORE_XLEN-1:0] em_csr_data_mem_data;
  logic                 em_mem_read;
  logic                 em_mem_write;
  logic [2:0]           em_mem_op_type;
  logic [4:0]           em_rd;
  logic                 em_reg_write;
  logic [11:0]          em_csr;
  logic                 em_csr_write;

  modport master (
    output em_valid, em_reg_data_mem_addr, em_csr_data_mem_data, em_mem_read,
           em_mem_write, em_mem_op_type, em_rd, em_reg_write, em_csr, em_csr_write,
    input  em_ready
  );

  modport slave (
    input  em_valid, em_reg_data_mem_addr, em_csr_data_mem_data, em_mem_read,
           em_mem_write, em_mem_op_type, em_rd, em_reg_write, em_csr, em_csr_write,
    output em_ready
  );
endinterface

interface core_mem_dbus_if;
  import core_mem_pkg::*;

  logic                 dbus_valid;
  logic                 dbus_ready;
  logic [CORE_XLEN-1:0] dbus_addr;
  logic                 dbus_we;
  logic [3:0]           dbus_wstrb;
  logic [CORE_XLEN-1:0] dbus_wdata;
  logic                 dbus_rvalid;
  logic [CORE_XLEN-1:0] dbus_rdata;

  modport master (
    output dbus_valid, dbus_addr, dbus_we, dbus_wstrb, dbus_wdata,
    input  dbus_ready, dbus_rvalid, dbus_rdata
  );

  modport slave (
    input  dbus_valid, dbus_addr, dbus_we, dbus_wstrb, dbus_wdata,
    output dbus_ready, dbus_rvalid, dbus_rdata
  );
endinterface

// File: rtl/core_mem_align.sv
// Combinational alignment logic: misalign detection, store lane steering,
// and load lane extraction with sign/zero extension.
module core_mem_align
  import core_mem_pkg::*;
(
  input  logic [2:0]           i_op,
  input  logic [1:0]           i_addr_lo,
  input  logic [CORE_XLEN-1:0] i_st_data,
  output logic                 o_misalign,
  output logic [3:0]           o_st_strb,
  output logic [CORE_XLEN-1:0] o_st_data,
  input  logic [2:0]           i_ld_op,
  input  logic [1:0]           i_ld_off,
  input  logic [CORE_XLEN-1:0] i_ld_word,
  output logic [CORE_XLEN-1:0] o_ld_data
);

  mem_size_e            w_st_size;
  mem_size_e            w_ld_size;
  logic [CORE_XLEN-1:0] w_ld_shift;

  assign w_st_size  = op_size(i_op);
  assign w_ld_size  = op_size(i_ld_op);
  assign w_ld_shift = i_ld_word >> {i_ld_off, 3'b000};

  always_comb begin
    o_misalign = 1'b0;
    o_st_strb  = 4'hF;
    o_st_data  = i_st_data;
    case (w_st_size)
      SZ_B: begin
        o_st_strb = 4'b0001 << i_addr_lo;
        o_st_data = {4{i_st_data[7:0]}};
      end
      SZ_H: begin
        o_misalign = i_addr_lo[0];
        o_st_strb  = 4'b0011 << i_addr_lo;
        o_st_data  = {2{i_st_data[15:0]}};
      end
      default: o_misalign = |i_addr_lo;
    endcase
  end

  always_comb begin
    o_ld_data = i_ld_word;
    case (w_ld_size)
      SZ_B: o_ld_data = (i_ld_op == MEM_BU) ? {24'b0, w_ld_shift[7:0]}
                                            : {{24{w_ld_shift[7]}}, w_ld_shift[7:0]};
      SZ_H: o_ld_data = (i_ld_op == MEM_HU) ? {16'b0, w_ld_shift[15:0]}
                                            : {{16{w_ld_shift[15]}}, w_ld_shift[15:0]};
      default: o_ld_data = i_ld_word;
    endcase
  end

endmodule

// File: rtl/core_mem.sv
// MEM stage: consumes EX/MEM entries, issues data-bus loads/stores and
// drives the MEM/WB register, including load data alignment.
module core_mem
  import core_mem_pkg::*;
#(
  parameter int unsigned XLEN = CORE_XLEN
) (
  input  logic               clk,
  input  logic               rest,
  core_mem_em_if.slave       em,
  core_mem_dbus_if.master    dbus,
  output logic               mw_valid,
  output logic [4:0]         mw_rd,
  output logic               mw_reg_write,
  output logic [XLEN-1:0]    mw_reg_write_data,
  output logic               mw_mem_data_valid,
  output logic [11:0]        mw_csr,
  output logic               mw_csr_write,
  output logic [XLEN-1:0]    mw_csr_data,
  output logic               mem_exc_valid,
  output logic [XLEN-1:0]    mem_exc_cause,
  output logic [XLEN-1:0]    mem_exc_addr
);

  state_e            r_state;
  logic              r_mw_valid;
  logic [4:0]        r_mw_rd;
  logic              r_mw_reg_write;
  logic [XLEN-1:0]   r_mw_data;
  logic              r_mw_mdv;
  logic [11:0]       r_mw_csr;
  logic              r_mw_csr_write;
  logic [XLEN-1:0]   r_mw_csr_data;
  logic              r_exc_valid;
  logic [XLEN-1:0]   r_exc_cause;
  logic [XLEN-1:0]   r_exc_addr;
  logic [2:0]        r_ld_op;
  logic [1:0]        r_ld_off;

  logic              w_is_load;
  logic              w_is_store;
  logic              w_is_mem;
  logic              w_misalign_raw;
  logic              w_misalign;
  logic              w_idle;
  logic              w_accept;
  logic [3:0]        w_st_strb;
  logic [XLEN-1:0]   w_st_data;
  logic [XLEN-1:0]   w_ld_data;

  core_mem_align u_align (
    .i_op       (em.em_mem_op_type),
    .i_addr_lo  (em.em_reg_data_mem_addr[1:0]),
    .i_st_data  (em.em_csr_data_mem_data),
    .o_misalign (w_misalign_raw),
    .o_st_strb  (w_st_strb),
    .o_st_data  (w_st_data),
    .i_ld_op    (r_ld_op),
    .i_ld_off   (r_ld_off),
    .i_ld_word  (dbus.dbus_rdata),
    .o_ld_data  (w_ld_data)
  );

  // A load flagged alongside a store is handled as a load.
  assign w_is_load  = em.em_mem_read;
  assign w_is_store = em.em_mem_write && !em.em_mem_read;
  assign w_is_mem   = w_is_load || w_is_store;
  assign w_misalign = w_is_mem && w_misalign_raw;
  assign w_idle     = (r_state == IDLE);

  assign em.em_ready = w_idle && (!em.em_valid || !w_is_mem || w_misalign || dbus.dbus_ready);
  assign w_accept    = em.em_valid && em.em_ready;

  assign dbus.dbus_valid = em.em_valid && w_is_mem && !w_misalign && w_idle;
  assign dbus.dbus_addr  = {em.em_reg_data_mem_addr[XLEN-1:2], 2'b00};
  assign dbus.dbus_we    = w_is_store;
  assign dbus.dbus_wstrb = w_is_store ? w_st_strb : 4'b0000;
  assign dbus.dbus_wdata = w_st_data;

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      r_state        <= IDLE;
      r_mw_valid     <= 1'b0;
      r_mw_rd        <= '0;
      r_mw_reg_write <= 1'b0;
      r_mw_data      <= '0;
      r_mw_mdv       <= 1'b0;
      r_mw_csr       <= '0;
      r_mw_csr_write <= 1'b0;
      r_mw_csr_data  <= '0;
      r_exc_valid    <= 1'b0;
      r_exc_cause    <= '0;
      r_exc_addr     <= '0;
      r_ld_op        <= '0;
      r_ld_off       <= '0;
    end else begin
      r_exc_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_mw_valid     <= 1'b1;
            r_mw_rd        <= em.em_rd;
            r_mw_reg_write <= em.em_reg_write;
            r_mw_data      <= em.em_reg_data_mem_addr;
            r_mw_mdv       <= 1'b1;
            r_mw_csr       <= em.em_csr;
            r_mw_csr_write <= em.em_csr_write;
            r_mw_csr_data  <= em.em_csr_data_mem_data;
            if (w_misalign) begin
              r_mw_reg_write <= 1'b0;
              r_mw_csr_write <= 1'b0;
              r_exc_valid    <= 1'b1;
              r_exc_cause    <= w_is_load ? EXC_LOAD_MISALIGN : EXC_STORE_MISALIGN;
              r_exc_addr     <= em.em_reg_data_mem_addr;
            end else if (w_is_load) begin
              r_mw_mdv  <= 1'b0;
              r_mw_data <= '0;
              r_ld_op   <= em.em_mem_op_type;
              r_ld_off  <= em.em_reg_data_mem_addr[1:0];
              r_state   <= WAIT;
            end else if (w_is_store) begin
              r_mw_reg_write <= 1'b0;
            end
          end else begin
            r_mw_valid <= 1'b0;
          end
        end
        WAIT: begin
          // mw holds the pending load until its data returns.
          if (dbus.dbus_rvalid) begin
            r_mw_data <= w_ld_data;
            r_mw_mdv  <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mw_valid          = r_mw_valid;
  assign mw_rd             = r_mw_rd;
  assign mw_reg_write      = r_mw_reg_write;
  assign mw_reg_write_data = r_mw_data;
  assign mw_mem_data_valid = r_mw_mdv;
  assign mw_csr            = r_mw_csr;
  assign mw_csr_write      = r_mw_csr_write;
  assign mw_csr_data       = r_mw_csr_data;
  assign mem_exc_valid     = r_exc_valid;
  assign mem_exc_cause     = r_exc_cause;
  assign mem_exc_addr      = r_exc_addr;

endmodule

// File: tb/tb_core_mem.sv
// Self-checking bench for core_mem: directed scenarios followed by random
// traffic compared against a transaction-level model every cycle.
module tb_core_mem;
  import core_mem_pkg::*;

  logic clk = 1'b0;
  logic rest = 1'b0;
  always #5 clk = ~clk;

  core_mem_em_if   em_bus ();
  core_mem_dbus_if db_bus ();

  logic        mw_valid, mw_reg_write, mw_mem_data_valid, mw_csr_write, mem_exc_valid;
  logic [4:0]  mw_rd;
  logic [11:0] mw_csr;
  logic [31:0] mw_reg_write_data, mw_csr_data, mem_exc_cause, mem_exc_addr;

  core_mem #(.XLEN(32)) dut (
    .clk               (clk),
    .rest              (rest),
    .em                (em_bus),
    .dbus              (db_bus),
    .mw_valid          (mw_valid),
    .mw_rd             (mw_rd),
    .mw_reg_write      (mw_reg_write),
    .mw_reg_write_data (mw_reg_write_data),
    .mw_mem_data_valid (mw_mem_data_valid),
    .mw_csr            (mw_csr),
    .mw_csr_write      (mw_csr_write),
    .mw_csr_data       (mw_csr_data),
    .mem_exc_valid     (mem_exc_valid),
    .mem_exc_cause     (mem_exc_cause),
    .mem_exc_addr      (mem_exc_addr)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rules, written as plain arithmetic on byte counts.
  function automatic int unsigned f_size(input logic [2:0] op);
    if (op == 3'd0 || op == 3'd4) return 1;
    if (op == 3'd1 || op == 3'd5) return 2;
    return 4;
  endfunction

  function automatic bit f_mis(input logic [31:0] a, input logic [2:0] op);
    return (a % f_size(op)) != 0;
  endfunction

  function automatic logic [3:0] f_strb(input logic [31:0] a, input logic [2:0] op);
    int unsigned s;
    s = ((1 << f_size(op)) - 1) << (a % 4);
    return s[3:0];
  endfunction

  function automatic logic [31:0] f_wdata(input logic [31:0] d, input logic [2:0] op);
    case (f_size(op))
      1:       return (d & 32'hFF) * 32'h0101_0101;
      2:       return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] f_ld(input logic [31:0] w, input logic [31:0] a, input logic [2:0] op);
    int unsigned sz;
    logic [31:0] v;
    sz = f_size(op);
    if (sz == 4) return w;
    v = (w >> (8 * (a % 4))) & ((32'd1 << (8 * sz)) - 1);
    if ((op == 3'd0 || op == 3'd1) && v >= (32'd1 << (8 * sz - 1)))
      v = v - (32'd1 << (8 * sz));
    return v;
  endfunction

  task automatic em_set(input bit v, input bit rd_, input bit wr_, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rd,
                        input bit rw, input logic [11:0] csr, input bit cw);
    em_bus.em_valid             = v;
    em_bus.em_mem_read          = rd_;
    em_bus.em_mem_write         = wr_;
    em_bus.em_mem_op_type       = op;
    em_bus.em_reg_data_mem_addr = addr;
    em_bus.em_csr_data_mem_data = data;
    em_bus.em_rd                = rd;
    em_bus.em_reg_write         = rw;
    em_bus.em_csr               = csr;
    em_bus.em_csr_write         = cw;
  endtask

  task automatic rand_entry();
    int unsigned k;
    logic [2:0]  op;
    logic [31:0] a;
    k  = $urandom_range(0, 9);
    op = 3'($urandom_range(0, 7));
    a  = $urandom;
    if ($urandom % 2 == 0) a = a - (a % f_size(op));
    if (k < 4)
      em_set(($urandom % 4) != 0, 0, 0, op, a, $urandom, 5'($urandom), 1'($urandom), 12'($urandom), 1'($urandom));
    else if (k < 7)
      em_set(($urandom % 4) != 0, 1, 0, op, a, $urandom, 5'($urandom), 1'($urandom), 12'($urandom), 0);
    else
      em_set(($urandom % 4) != 0, 0, 1, op, a, $urandom, 5'($urandom), 1'($urandom), 12'($urandom), 0);
  endtask

  // Model state: expected MEM/WB contents and whether a load is outstanding.
  bit          chk_on = 0;
  bit          m_wait;
  logic [31:0] m_ld_addr;
  logic [2:0]  m_ld_op;
  bit          x_valid, x_rw, x_mdv, x_cw, x_exc, x_chk_data, x_chk_csr, x_chk_mdv;
  logic [4:0]  x_rd;
  logic [11:0] x_csr;
  logic [31:0] x_data, x_csrd, x_cause, x_eaddr;
  bit          c_v, c_ld, c_st, c_mem, c_mis, c_rdy, c_dv;
  logic [31:0] c_a;
  logic [2:0]  c_op;

  task automatic model_reset();
    m_wait = 0; m_ld_addr = '0; m_ld_op = '0;
    x_valid = 0; x_rw = 0; x_mdv = 0; x_cw = 0; x_exc = 0;
    x_chk_data = 0; x_chk_csr = 0; x_chk_mdv = 0;
    x_rd = '0; x_csr = '0; x_data = '0; x_csrd = '0; x_cause = '0; x_eaddr = '0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      #2;
      if (chk_on) begin
        if (!rest) begin
          chk("rand_reset_outs", 32'(|{mw_valid, mw_rd, mw_reg_write, mw_reg_write_data, mw_mem_data_valid,
              mw_csr, mw_csr_write, mw_csr_data, mem_exc_valid, mem_exc_cause, mem_exc_addr}), 0);
          model_reset();
        end else begin
          chk("mw_valid", 32'(mw_valid), 32'(x_valid));
          chk("exc_valid", 32'(mem_exc_valid), 32'(x_exc));
          if (x_valid) begin
            chk("mw_rd", 32'(mw_rd), 32'(x_rd));
            chk("mw_reg_write", 32'(mw_reg_write), 32'(x_rw));
            chk("mw_csr_write", 32'(mw_csr_write), 32'(x_cw));
            if (x_chk_mdv) chk("mw_mdv", 32'(mw_mem_data_valid), 32'(x_mdv));
            if (x_chk_data) chk("mw_data", mw_reg_write_data, x_data);
            if (x_chk_csr) begin
              chk("mw_csr", 32'(mw_csr), 32'(x_csr));
              chk("mw_csr_data", mw_csr_data, x_csrd);
            end
          end
          if (x_exc) begin
            chk("exc_cause", mem_exc_cause, x_cause);
            chk("exc_addr", mem_exc_addr, x_eaddr);
          end

          c_v   = em_bus.em_valid;
          c_ld  = em_bus.em_mem_read;
          c_st  = em_bus.em_mem_write && !em_bus.em_mem_read;
          c_mem = c_ld || c_st;
          c_a   = em_bus.em_reg_data_mem_addr;
          c_op  = em_bus.em_mem_op_type;
          c_mis = c_mem && f_mis(c_a, c_op);
          c_rdy = !m_wait && (!c_v || !c_mem || c_mis || db_bus.dbus_ready);
          c_dv  = c_v && c_mem && !c_mis && !m_wait;
          chk("em_ready", 32'(em_bus.em_ready), 32'(c_rdy));
          chk("dbus_valid", 32'(db_bus.dbus_valid), 32'(c_dv));
          if (c_dv) begin
            chk("dbus_addr", db_bus.dbus_addr, c_a - (c_a % 4));
            chk("dbus_we", 32'(db_bus.dbus_we), 32'(c_st));
            chk("dbus_wstrb", 32'(db_bus.dbus_wstrb), c_st ? 32'(f_strb(c_a, c_op)) : 32'd0);
            if (c_st) chk("dbus_wdata", db_bus.dbus_wdata, f_wdata(em_bus.em_csr_data_mem_data, c_op));
          end

          x_exc = 0;
          if (m_wait) begin
            if (db_bus.dbus_rvalid) begin
              x_data = f_ld(db_bus.dbus_rdata, m_ld_addr, m_ld_op);
              x_mdv = 1; x_chk_data = 1; m_wait = 0;
            end
          end else if (c_v && c_rdy) begin
            x_valid = 1; x_rd = em_bus.em_rd; x_csr = em_bus.em_csr;
            x_csrd = em_bus.em_csr_data_mem_data; x_chk_mdv = 1;
            if (!c_mem) begin
              x_rw = em_bus.em_reg_write; x_cw = em_bus.em_csr_write; x_mdv = 1;
              x_data = c_a; x_chk_data = 1; x_chk_csr = 1;
            end else if (c_mis) begin
              x_rw = 0; x_cw = 0; x_chk_mdv = 0; x_chk_data = 0; x_chk_csr = 0;
              x_exc = 1; x_cause = c_ld ? 32'd4 : 32'd6; x_eaddr = c_a;
            end else if (c_ld) begin
              x_rw = em_bus.em_reg_write; x_cw = em_bus.em_csr_write; x_mdv = 0;
              x_data = 0; x_chk_data = 1; x_chk_csr = 0;
              m_wait = 1; m_ld_addr = c_a; m_ld_op = c_op;
            end else begin
              x_rw = 0; x_cw = em_bus.em_csr_write; x_mdv = 1; x_chk_data = 0; x_chk_csr = 0;
            end
          end else begin
            x_valid = 0;
          end
        end
      end
    end
  end

  bit          acc;
  int unsigned pend, rst_cnt;

  initial begin
    em_set(0, 0, 0, 3'd0, '0, '0, '0, 0, '0, 0);
    db_bus.dbus_ready  = 1'b0;
    db_bus.dbus_rvalid = 1'b0;
    db_bus.dbus_rdata  = '0;

    chk("pin_ld_h", f_ld(32'h8001_5678, 32'h102, 3'd1), 32'hFFFF_8001);
    chk("pin_ld_bu", f_ld(32'h8001_F678, 32'h101, 3'd4), 32'h0000_00F6);
    chk("pin_strb_b", 32'(f_strb(32'h103, 3'd0)), 32'h8);
    chk("pin_wdata_b", f_wdata(32'h0000_00A5, 3'd0), 32'hA5A5_A5A5);

    @(negedge clk); #1;
    chk("t0_reset_outs", 32'(|{mw_valid, mw_reg_write_data, mw_mem_data_valid, mem_exc_valid,
        mem_exc_cause, mw_rd, mw_csr_write}), 0);
    @(negedge clk); rest = 1'b1;

    // ALU op
    @(negedge clk);
    em_set(1, 0, 0, 3'd0, 32'h1234, 32'h0, 5'd5, 1, 12'h0, 0);
    db_bus.dbus_ready = 1'b1;
    #1 chk("t1_em_ready", 32'(em_bus.em_ready), 1);
    // SB 0x103
    @(negedge clk);
    em_set(1, 0, 1, 3'd0, 32'h103, 32'hA5, 5'd1, 1, 12'h0, 0);
    #1;
    chk("t1_mw_valid", 32'(mw_valid), 1);
    chk("t1_mw_rd", 32'(mw_rd), 5);
    chk("t1_mw_data", mw_reg_write_data, 32'h1234);
    chk("t1_mw_mdv", 32'(mw_mem_data_valid), 1);
    chk("t2_dbus_valid", 32'(db_bus.dbus_valid), 1);
    chk("t2_dbus_addr", db_bus.dbus_addr, 32'h100);
    chk("t2_dbus_wstrb", 32'(db_bus.dbus_wstrb), 32'b1000);
    chk("t2_dbus_wdata", db_bus.dbus_wdata, 32'hA5A5_A5A5);
    // LH 0x102
    @(negedge clk);
    em_set(1, 1, 0, 3'd1, 32'h102, 32'h0, 5'd9, 1, 12'h0, 0);
    #1;
    chk("t2_mw_valid", 32'(mw_valid), 1);
    chk("t2_mw_reg_write", 32'(mw_reg_write), 0);
    chk("t3_dbus_valid", 32'(db_bus.dbus_valid), 1);
    chk("t3_dbus_we", 32'(db_bus.dbus_we), 0);
    chk("t3_dbus_wstrb", 32'(db_bus.dbus_wstrb), 0);
    chk("t3_dbus_addr", db_bus.dbus_addr, 32'h100);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      em_set(1, 0, 0, 3'd0, 32'hBEEF, 32'h0, 5'd7, 1, 12'h0, 0);
      if (i == 2) begin
        db_bus.dbus_rvalid = 1'b1;
        db_bus.dbus_rdata  = 32'h8001_5678;
      end
      #1;
      chk("t3_wait_em_ready", 32'(em_bus.em_ready), 0);
      chk("t3_wait_mdv", 32'(mw_mem_data_valid), 0);
      chk("t3_wait_mw_valid", 32'(mw_valid), 1);
      chk("t3_wait_data", mw_reg_write_data, 0);
    end
    @(negedge clk);
    db_bus.dbus_rvalid = 1'b0;
    #1;
    chk("t3_ld_data", mw_reg_write_data, 32'hFFFF_8001);
    chk("t3_ld_mdv", 32'(mw_mem_data_valid), 1);
    chk("t3_ld_rd", 32'(mw_rd), 9);
    chk("t3_idle_em_ready", 32'(em_bus.em_ready), 1);
    // LW 0x201 (misaligned)
    @(negedge clk);
    em_set(1, 1, 0, 3'd2, 32'h201, 32'h0, 5'd3, 1, 12'h0, 0);
    #1;
    chk("t3_alu_after_data", mw_reg_write_data, 32'hBEEF);
    chk("t4_dbus_valid", 32'(db_bus.dbus_valid), 0);
    chk("t4_em_ready", 32'(em_bus.em_ready), 1);
    // SW 0x300 with bus stall
    @(negedge clk);
    em_set(1, 0, 1, 3'd2, 32'h300, 32'hCAFE_F00D, 5'd2, 0, 12'h0, 0);
    db_bus.dbus_ready = 1'b0;
    #1;
    chk("t4_exc_valid", 32'(mem_exc_valid), 1);
    chk("t4_exc_cause", mem_exc_cause, 4);
    chk("t4_exc_addr", mem_exc_addr, 32'h201);
    chk("t4_mw_valid", 32'(mw_valid), 1);
    chk("t4_mw_reg_write", 32'(mw_reg_write), 0);
    chk("t5_dbus_valid0", 32'(db_bus.dbus_valid), 1);
    chk("t5_em_ready0", 32'(em_bus.em_ready), 0);
    @(negedge clk); #1;
    chk("t5_dbus_valid1", 32'(db_bus.dbus_valid), 1);
    chk("t5_em_ready1", 32'(em_bus.em_ready), 0);
    chk("t5_mw_valid_stall", 32'(mw_valid), 0);
    chk("t4_exc_pulse_end", 32'(mem_exc_valid), 0);
    @(negedge clk);
    db_bus.dbus_ready = 1'b1;
    #1;
    chk("t5_em_ready2", 32'(em_bus.em_ready), 1);
    chk("t5_wstrb", 32'(db_bus.dbus_wstrb), 32'hF);
    chk("t5_wdata", db_bus.dbus_wdata, 32'hCAFE_F00D);
    // LW 0x400, then reset while waiting
    @(negedge clk);
    em_set(1, 1, 0, 3'd2, 32'h400, 32'h0, 5'd4, 1, 12'h0, 0);
    #1 chk("t5_mw_valid", 32'(mw_valid), 1);
    @(negedge clk);
    em_bus.em_valid = 1'b0;
    rest = 1'b0;
    #1;
    chk("t6_reset_outs", 32'(|{mw_valid, mw_rd, mw_reg_write, mw_reg_write_data, mw_mem_data_valid,
        mw_csr, mw_csr_write, mw_csr_data, mem_exc_valid, mem_exc_cause, mem_exc_addr}), 0);
    chk("t6_em_ready", 32'(em_bus.em_ready), 1);
    @(negedge clk);
    rest = 1'b1;
    db_bus.dbus_rvalid = 1'b1;
    db_bus.dbus_rdata  = 32'h1111_2222;
    #1 chk("t6_em_ready_after", 32'(em_bus.em_ready), 1);
    @(negedge clk);
    db_bus.dbus_rvalid = 1'b0;
    #1 chk("t6_rvalid_ignored", 32'(|{mw_valid, mw_mem_data_valid, mw_reg_write_data}), 0);

    // Random phase: starts from a fresh reset so the model and DUT agree.
    @(negedge clk);
    rest = 1'b0;
    chk_on = 1;
    acc = 0; pend = 0; rst_cnt = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (rst_cnt > 0) begin
        rest = 1'b0;
        rst_cnt--;
      end else begin
        rest = 1'b1;
        if ((pend > 1 && $urandom % 10 == 0) || $urandom % 400 == 0) begin
          rest = 1'b0;
          rst_cnt = 1;
        end
      end
      db_bus.dbus_rvalid = 1'b0;
      db_bus.dbus_rdata  = $urandom;
      if (pend > 0) begin
        pend--;
        if (pend == 0) db_bus.dbus_rvalid = 1'b1;
      end else if ($urandom % 8 == 0) begin
        db_bus.dbus_rvalid = 1'b1;
      end
      db_bus.dbus_ready = ($urandom % 3) != 0;
      if (acc || !em_bus.em_valid || $urandom % 16 == 0) rand_entry();
      #1;
      acc = em_bus.em_valid && em_bus.em_ready && rest;
      if (acc && db_bus.dbus_valid && !db_bus.dbus_we) pend = $urandom_range(1, 4);
    end
    @(negedge clk);
    chk_on = 0;
    #3;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
